// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared types and constants for the PWM ramp controller.
//   state_e  : ramp sequencer FSM state encoding
//   PWM_WIDTH: default duty/counter width
//   CNT_MAX  : last counter value for the default width (period = CNT_MAX+1)
//   cnt_max(): last counter value for an arbitrary width
// -----------------------------------------------------------------------------
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RAMP_DOWN = 2'd2
    } state_e;

    localparam int unsigned PWM_WIDTH = 32'd8;
    localparam int unsigned CNT_MAX   = (32'd2 ** PWM_WIDTH) - 32'd1;

    function automatic int unsigned cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_core.sv
// -----------------------------------------------------------------------------
// pwm_core
// Free-running period counter, period-boundary duty shadow register and the
// registered PWM output.
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-low reset
//   enable       in   1 = count; 0 = counter held at 0 and dout forced low
//   duty_in      in   duty value loaded into the shadow at period end
//   period_end   out  enable & (cnt == last count)
//   period_start out  enable & (cnt == 0)
//   dout         out  registered PWM output (one cycle behind the compare)
// -----------------------------------------------------------------------------
module pwm_core
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] duty_in,
    output logic             period_end,
    output logic             period_start,
    output logic             dout
);

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(cnt_max(WIDTH));

    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] duty_active_r;
    logic             dout_r;

    assign period_end   = enable & (cnt_r == CNT_LAST);
    assign period_start = enable & (cnt_r == {WIDTH{1'b0}});
    assign dout         = dout_r;

    // Period counter: wraps naturally at the top, parked at zero while disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (enable) begin
            cnt_r <= cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= {WIDTH{1'b0}};
        end
    end

    // Duty shadow: only reloaded at the last count so a pulse is never cut short.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_active_r <= {WIDTH{1'b0}};
        end else if (period_end) begin
            duty_active_r <= duty_in;
        end else begin
            duty_active_r <= duty_active_r;
        end
    end

    // PWM compare, registered so the output is glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_r <= 1'b0;
        end else begin
            dout_r <= enable & (cnt_r < duty_active_r);
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_ramp_ctrl
// Ramp sequencer in front of a PWM generator. A target duty is accepted over a
// valid/ready port and duty_cur is walked toward it by a fixed step once per
// PWM period; the new duty takes effect from the following period start.
//   clk, rst      clock / asynchronous active-low reset
//   enable        PWM and ramp run enable (0 pauses the ramp)
//   cmd_valid/cmd_ready/cmd_target/cmd_step   command handshake
//   abort         stop ramping, keep current duty
//   dout          PWM output (registered)
//   duty_cur      duty in effect for the current/next period
//   busy          ramp in progress
//   done          one-cycle pulse when duty_cur reaches the target
//   period_start  one-cycle pulse at counter zero while enabled
// -----------------------------------------------------------------------------
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int WIDTH  = PWM_WIDTH,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WIDTH-1:0]  cmd_target,
    input  logic [STEP_W-1:0] cmd_step,
    input  logic              abort,
    output logic              dout,
    output logic [WIDTH-1:0]  duty_cur,
    output logic              busy,
    output logic              done,
    output logic              period_start
);

    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_r;
    state_e           state_nxt_s;
    logic [WIDTH-1:0] target_r;
    logic [WIDTH-1:0] step_r;
    logic [WIDTH-1:0] duty_cur_r;
    logic [WIDTH-1:0] duty_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    logic             accept_s;
    logic             period_end_s;
    logic [WIDTH-1:0] step_eff_s;
    logic [WIDTH-1:0] diff_s;

    assign cmd_ready  = (state_r == ST_IDLE) & ~abort;
    assign accept_s   = cmd_valid & cmd_ready;
    // A zero step would never converge, so it is promoted to one.
    assign step_eff_s = (cmd_step == {STEP_W{1'b0}}) ? ONE_W : WIDTH'(cmd_step);
    assign busy       = (state_r != ST_IDLE);
    assign done       = done_r;
    assign duty_cur   = duty_cur_r;

    // Next state, next duty and done pulse; abort overrides any pending step.
    always_comb begin
        state_nxt_s = state_r;
        duty_nxt_s  = duty_cur_r;
        done_nxt_s  = 1'b0;
        diff_s      = {WIDTH{1'b0}};
        if (abort) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (cmd_target > duty_cur_r) begin
                            state_nxt_s = ST_RAMP_UP;
                        end else if (cmd_target < duty_cur_r) begin
                            state_nxt_s = ST_RAMP_DOWN;
                        end else begin
                            done_nxt_s = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RAMP_UP: begin
                    diff_s = target_r - duty_cur_r;
                    if (period_end_s) begin
                        // Saturate onto the target instead of overshooting.
                        if (diff_s <= step_r) begin
                            duty_nxt_s  = target_r;
                            done_nxt_s  = 1'b1;
                            state_nxt_s = ST_IDLE;
                        end else begin
                            duty_nxt_s = duty_cur_r + step_r;
                        end
                    end else begin
                        duty_nxt_s = duty_cur_r;
                    end
                end
                ST_RAMP_DOWN: begin
                    diff_s = duty_cur_r - target_r;
                    if (period_end_s) begin
                        if (diff_s <= step_r) begin
                            duty_nxt_s  = target_r;
                            done_nxt_s  = 1'b1;
                            state_nxt_s = ST_IDLE;
                        end else begin
                            duty_nxt_s = duty_cur_r - step_r;
                        end
                    end else begin
                        duty_nxt_s = duty_cur_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM, duty and done registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            duty_cur_r <= {WIDTH{1'b0}};
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            duty_cur_r <= duty_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    // Command capture on handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target_r <= {WIDTH{1'b0}};
            step_r   <= ONE_W;
        end else if (accept_s) begin
            target_r <= cmd_target;
            step_r   <= step_eff_s;
        end else begin
            target_r <= target_r;
            step_r   <= step_r;
        end
    end

    // The shadow loads duty_nxt_s so a step and its first use share one edge.
    pwm_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .duty_in      (duty_nxt_s),
        .period_end   (period_end_s),
        .period_start (period_start),
        .dout         (dout)
    );

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_ramp_ctrl
// Directed bench for pwm_ramp_ctrl with WIDTH=4, STEP_W=2 (16-cycle period).
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pwm_ramp_ctrl;

    localparam int WIDTH  = 4;
    localparam int STEP_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [WIDTH-1:0]  cmd_target = 4'd0;
    logic [STEP_W-1:0] cmd_step = 2'd0;
    logic              abort = 1'b0;
    logic              dout;
    logic [WIDTH-1:0]  duty_cur;
    logic              busy;
    logic              done;
    logic              period_start;

    int n_checks = 0;
    int n_errors = 0;

    pwm_ramp_ctrl #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_target   (cmd_target),
        .cmd_step     (cmd_step),
        .abort        (abort),
        .dout         (dout),
        .duty_cur     (duty_cur),
        .busy         (busy),
        .done         (done),
        .period_start (period_start)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge that sees period_start (cnt == 0).
    task automatic wait_ps();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 40);
        check_eq("period_start_seen", {31'd0, period_start}, 32'd1);
    endtask

    // Present one command for a single rising edge; returns in cycle T+1.
    task automatic send_cmd(input logic [WIDTH-1:0] tgt, input logic [STEP_W-1:0] stp);
        cmd_valid  = 1'b1;
        cmd_target = tgt;
        cmd_step   = stp;
        @(posedge clk);
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    initial begin
        int ps_cnt;
        int hi_cnt;
        int first_ps;
        int bad;
        int exp_up[4];
        int exp_up15[5];
        exp_up   = '{3, 6, 9, 10};
        exp_up15 = '{3, 6, 9, 12, 15};

        // 1. reset held with enable high
        repeat (3) @(negedge clk);
        check_eq("rst_dout", {31'd0, dout}, 32'd0);
        check_eq("rst_duty", {28'd0, duty_cur}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
        rst = 1'b1;
        ps_cnt = 0; hi_cnt = 0; first_ps = -1;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (period_start) begin
                ps_cnt++;
                if (first_ps < 0) first_ps = i;
            end
            if (dout) hi_cnt++;
        end
        check_eq("idle_ps_count", ps_cnt, 32'd3);
        check_eq("idle_first_ps", first_ps, 32'd15);
        check_eq("idle_dout_high", hi_cnt, 32'd0);

        // 2. ramp up 0 -> 10 step 3
        wait_ps();
        send_cmd(4'd10, 2'd3);
        check_eq("up_busy", {31'd0, busy}, 32'd1);
        check_eq("up_ready", {31'd0, cmd_ready}, 32'd0);
        check_eq("up_duty0", {28'd0, duty_cur}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            wait_ps();
            check_eq("up_duty", {28'd0, duty_cur}, exp_up[k]);
            check_eq("up_done", {31'd0, done}, (k == 3) ? 32'd1 : 32'd0);
            check_eq("up_busy_k", {31'd0, busy}, (k == 3) ? 32'd0 : 32'd1);
        end
        hi_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) check_eq("up_done_clear", {31'd0, done}, 32'd0);
            if (dout) hi_cnt++;
        end
        check_eq("duty10_high", hi_cnt, 32'd10);

        // 3. ramp down 10 -> 2 with step 0, competing command held
        wait_ps();
        send_cmd(4'd2, 2'd0);
        cmd_valid  = 1'b1;
        cmd_target = 4'd15;
        cmd_step   = 2'd3;
        for (int i = 0; i < 8; i++) begin
            wait_ps();
            check_eq("dn_duty", {28'd0, duty_cur}, 32'd9 - i);
            if (i < 7) begin
                check_eq("dn_ready", {31'd0, cmd_ready}, 32'd0);
                check_eq("dn_done", {31'd0, done}, 32'd0);
            end else begin
                check_eq("dn_done_last", {31'd0, done}, 32'd1);
                check_eq("dn_busy_last", {31'd0, busy}, 32'd0);
                cmd_valid = 1'b0;
            end
        end
        wait_ps();
        check_eq("dn_hold_duty", {28'd0, duty_cur}, 32'd2);
        check_eq("dn_hold_busy", {31'd0, busy}, 32'd0);

        // 4. abort coincident with period_end at duty 6
        wait_ps();
        send_cmd(4'd12, 2'd2);
        wait_ps();
        check_eq("ab_duty4", {28'd0, duty_cur}, 32'd4);
        wait_ps();
        check_eq("ab_duty6", {28'd0, duty_cur}, 32'd6);
        repeat (15) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("ab_duty", {28'd0, duty_cur}, 32'd6);
        check_eq("ab_busy", {31'd0, busy}, 32'd0);
        check_eq("ab_done", {31'd0, done}, 32'd0);
        check_eq("ab_ready_hi", {31'd0, cmd_ready}, 32'd0);
        abort = 1'b0;
        #1;
        check_eq("ab_ready_lo", {31'd0, cmd_ready}, 32'd1);
        wait_ps();
        check_eq("ab_hold_duty", {28'd0, duty_cur}, 32'd6);

        // 5. equal target, then 0 -> 15 step 3
        wait_ps();
        send_cmd(4'd6, 2'd1);
        check_eq("eq_done", {31'd0, done}, 32'd1);
        check_eq("eq_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_eq("eq_done_clear", {31'd0, done}, 32'd0);
        check_eq("eq_busy2", {31'd0, busy}, 32'd0);
        wait_ps();
        send_cmd(4'd0, 2'd3);
        wait_ps();
        check_eq("z_duty3", {28'd0, duty_cur}, 32'd3);
        wait_ps();
        check_eq("z_duty0", {28'd0, duty_cur}, 32'd0);
        check_eq("z_done", {31'd0, done}, 32'd1);
        wait_ps();
        send_cmd(4'd15, 2'd3);
        for (int k = 0; k < 5; k++) begin
            wait_ps();
            check_eq("f_duty", {28'd0, duty_cur}, exp_up15[k]);
        end
        check_eq("f_done", {31'd0, done}, 32'd1);
        hi_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (!dout) hi_cnt++;
        end
        check_eq("duty15_low", hi_cnt, 32'd1);

        // 6a. enable dropped mid-ramp
        wait_ps();
        send_cmd(4'd0, 2'd1);
        wait_ps();
        check_eq("en_duty14", {28'd0, duty_cur}, 32'd14);
        repeat (5) @(negedge clk);
        enable = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dout || period_start) bad++;
        end
        check_eq("en_off_quiet", bad, 32'd0);
        check_eq("en_off_duty", {28'd0, duty_cur}, 32'd14);
        check_eq("en_off_busy", {31'd0, busy}, 32'd1);
        enable = 1'b1;
        #1;
        check_eq("en_cnt_zero", {31'd0, period_start}, 32'd1);
        wait_ps();
        check_eq("en_resume", {28'd0, duty_cur}, 32'd13);

        // 6b. asynchronous reset between clock edges mid-ramp
        repeat (3) @(negedge clk);
        check_eq("pre_rst_dout", {31'd0, dout}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_dout", {31'd0, dout}, 32'd0);
        check_eq("arst_duty", {28'd0, duty_cur}, 32'd0);
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_done", {31'd0, done}, 32'd0);
        check_eq("arst_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        wait_ps();
        check_eq("post_rst_duty", {28'd0, duty_cur}, 32'd0);
        check_eq("post_rst_busy", {31'd0, busy}, 32'd0);
        wait_ps();
        check_eq("post_rst_duty2", {28'd0, duty_cur}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
